// File: rtl/mole_ctrl_pkg.sv
// Shared whack-a-mole definitions: FSM state encoding, hole count and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mole_ctrl_pkg;

    localparam int NUM_HOLES = 9;
    localparam int HOLE_W    = $clog2(NUM_HOLES);
    localparam int RND_W     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        PICK = 3'd2,
        UP   = 3'd3,
        OVER = 3'd4
    } state_e;

    typedef logic [HOLE_W-1:0] hole_t;

    // One-hot visible-mole vector for a hole index.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input hole_t h);
        return NUM_HOLES'(1) << h;
    endfunction

endpackage

// File: rtl/mole_ctrl_if.sv
// Player/LFSR-facing signal bundle of the mole controller.
// Latency: n/a (wiring only). master = stimulus side, slave = controller side.
// Backpressure: none; all signals are level/pulse, no handshake.
interface mole_ctrl_if;
    import mole_ctrl_pkg::*;

    logic                 start;      // single-cycle game start/restart pulse
    logic [RND_W-1:0]     rndnum;     // LFSR value, nominally 0..8
    logic [NUM_HOLES-1:0] hit;        // one pulse bit per hole button
    logic                 rnd_en;     // LFSR enable
    logic [NUM_HOLES-1:0] mole;       // one-hot visible mole
    logic [7:0]           score;      // successful hits, saturating
    logic [3:0]           misses;     // timed-out moles
    logic                 game_over;  // high while the game has ended

    modport master (
        output start, rndnum, hit,
        input  rnd_en, mole, score, misses, game_over
    );

    modport slave (
        input  start, rndnum, hit,
        output rnd_en, mole, score, misses, game_over
    );

endinterface

// File: rtl/wam_timer.sv
// Loadable down-counter timing the GAP and UP intervals; done while count is zero.
// Latency: load takes effect on the next edge; done is a decode of the count register.
// Backpressure: none. Ports: clk, reset (async active-low), load_i, load_val_i, done_o.
module wam_timer #(
    parameter int  MAX_COUNT = 50_000_000,
    localparam int W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mole_ctrl.sv
// Whack-a-mole game controller: gap, pick a hole, show mole, score hits / count misses.
// Latency: all outputs registered; a matching hit shows in score one cycle later.
// Backpressure: none. Ports: clk, reset (async active-low), bus (mole_ctrl_if.slave).
module mole_ctrl
    import mole_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES   = 25_000_000,
    parameter int UP_CYCLES    = 50_000_000,
    parameter int MAX_MISSES   = 5,
    parameter int PICK_RETRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    mole_ctrl_if.slave  bus
);

    localparam int TMAX = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(PICK_RETRIES + 1);

    // Timer runs from N-1 down to 0 so each interval is exactly N cycles.
    localparam logic [TW-1:0]    GAP_LD     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]    UP_LD      = TW'(UP_CYCLES - 1);
    localparam logic [PW-1:0]    PICK_LAST  = PW'(PICK_RETRIES - 1);
    localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISSES);
    localparam logic [RND_W-1:0] HOLE_MAX   = RND_W'(NUM_HOLES - 1);

    state_e               state_q, state_d;
    hole_t                hole_q, hole_d;
    hole_t                last_q, last_d;
    logic [7:0]           score_q, score_d;
    logic [3:0]           misses_q, misses_d;
    logic [PW-1:0]        pick_cnt_q, pick_cnt_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d;
    logic                 rnd_en_q, rnd_en_d;
    logic                 game_over_q, game_over_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_done;

    logic                 pick_ok;
    logic                 pick_forced;
    hole_t                pick_val;
    logic                 up_hit;

    wam_timer #(
        .MAX_COUNT (TMAX)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        hole_d      = hole_q;
        last_d      = last_q;
        score_d     = score_q;
        misses_d    = misses_q;
        pick_cnt_d  = '0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        pick_ok     = (bus.rndnum <= HOLE_MAX) && (hole_t'(bus.rndnum) != last_q);
        pick_forced = (pick_cnt_q == PICK_LAST);
        // Out-of-range values can only get through on the forced cycle; they map to hole 0.
        pick_val    = (bus.rndnum > HOLE_MAX) ? '0 : hole_t'(bus.rndnum);
        // Only the bit of the visible hole matters; any other pressed bits are don't-care.
        up_hit      = |(bus.hit & hole_onehot(hole_q));

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    score_d  = '0;
                    misses_d = '0;
                    last_d   = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                pick_cnt_d = pick_cnt_q + PW'(1);
                if (pick_ok || pick_forced) begin
                    hole_d  = pick_val;
                    last_d  = pick_val;
                    state_d = UP;
                end
            end
            UP: begin
                // A hit on the final dwell cycle wins over the timeout.
                if (up_hit) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    state_d = GAP;
                end else if (tmr_done) begin
                    misses_d = misses_q + 4'd1;
                    state_d  = (misses_d == MISS_LIMIT) ? OVER : GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reload on every state change so a new GAP/UP always gets its full length.
        if (state_d != state_q) begin
            tmr_load = 1'b1;
            tmr_val  = (state_d == GAP) ? GAP_LD :
                       (state_d == UP)  ? UP_LD  : '0;
        end

        // Outputs are decoded from the next state so the registers line up with the state.
        mole_d      = (state_d == UP) ? hole_onehot(hole_d) : '0;
        rnd_en_d    = (state_d == GAP) || (state_d == PICK);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hole_q      <= '0;
            last_q      <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            pick_cnt_q  <= '0;
            mole_q      <= '0;
            rnd_en_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hole_q      <= hole_d;
            last_q      <= last_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            pick_cnt_q  <= pick_cnt_d;
            mole_q      <= mole_d;
            rnd_en_q    <= rnd_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.rnd_en    = rnd_en_q;
    assign bus.mole      = mole_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.game_over = game_over_q;

endmodule
